// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM encodings and
// default timing constants.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  // 50 MHz / (16 * 19200) rounded
  localparam int DEFAULT_DVSR    = 163;
  localparam int DEFAULT_DVSR_W  = 8;
  localparam int DEFAULT_SB_TICK = 16;
  localparam int DEFAULT_DBIT    = 8;

  // Baud ticks per start or data bit
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider producing a one-clk tick every DVSR clocks; clr
// restarts the count so the following period is a full one.
module uart_baud_tick
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int DVSR   = DEFAULT_DVSR,
  parameter int DVSR_W = DEFAULT_DVSR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_reg;
  logic [DVSR_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (clr || (cnt_reg == LAST)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Tick marks the cycle in which the counter wraps back to zero
  assign tick = !clr && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops one byte from an upstream FIFO whenever it is
// non-empty and shifts it out LSB first on a registered tx line.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK,
  parameter int DVSR    = DEFAULT_DVSR,
  parameter int DVSR_W  = DEFAULT_DVSR_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [4:0]    LAST_OS   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

  state_t          state_reg, state_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [4:0]      s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic            tx_reg, tx_next;
  logic            tick;
  logic            clr;

  uart_baud_tick #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) baud (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        b_next     = DBIT'(fifo_data);
        s_next     = '0;
        n_next     = '0;
        state_next = START;
      end
      START: begin
        if (tick) begin
          if (s_reg == LAST_OS) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == LAST_OS) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == LAST_BIT) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_reg == STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Line level follows the state being entered so tx stays aligned with state_reg
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_comb begin
    fifo_rd      = (state_reg == IDLE) && !fifo_empty && !reset;
    tx_done_tick = (state_reg == STOP) && tick && (s_reg == STOP_LAST);
    tx_busy      = (state_reg != IDLE);
    clr          = (state_reg == LOAD);
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: two transmitters (1 and 2 stop bits) with DVSR=4, fed by a
// small FIFO model; a negedge monitor decodes frames and pops expectations.
module tb_uart_tx_fifo_drain;

  localparam int BIT_CLKS  = 64;
  localparam int BODY_CLKS = 9 * BIT_CLKS;

  typedef struct {
    logic [7:0] data;
    int         stop_clks;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fifo_empty;
  logic [7:0] fifo_data [2];
  logic [1:0] fifo_rd;
  logic [1:0] tx;
  logic [1:0] tx_busy;
  logic [1:0] tx_done_tick;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [2][16];
  int wr_ptr [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};

  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  always #5 clk = ~clk;

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty[0]),
    .fifo_data    (fifo_data[0]),
    .fifo_rd      (fifo_rd[0]),
    .tx           (tx[0]),
    .tx_busy      (tx_busy[0]),
    .tx_done_tick (tx_done_tick[0])
  );

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR(4), .DVSR_W(3)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty[1]),
    .fifo_data    (fifo_data[1]),
    .fifo_rd      (fifo_rd[1]),
    .tx           (tx[1]),
    .tx_busy      (tx_busy[1]),
    .tx_done_tick (tx_done_tick[1])
  );

  // FIFO model: data_out updates on the read edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd[i]) begin
        fifo_data[i] <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i]    <= rd_ptr[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_byte(input int inst, input logic [7:0] d, input int stop_clks, input bit b2b);
    exp_t e;
    e.data      = d;
    e.stop_clks = stop_clks;
    e.b2b       = b2b;
    if (inst == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
    mem[inst][wr_ptr[inst] % 16] = d;
    wr_ptr[inst] = wr_ptr[inst] + 1;
  endtask

  // Monitor state
  int         cyc = 0;
  bit         in_f      [2];
  int         t_cnt     [2];
  int         stop_cnt  [2];
  logic [8:0] samp      [2];
  bit         stable    [2];
  logic       cur_bit   [2];
  logic       prev_tx   [2];
  logic       prev_rd   [2];
  int         last_done [2];
  int         done_cnt  [2] = '{0, 0};
  exp_t       cur       [2];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        in_f[i]    = 1'b0;
        prev_tx[i] = 1'b1;
        prev_rd[i] = 1'b0;
      end else begin
        if (fifo_rd[i]) begin
          chk("fifo_rd_legal", {fifo_empty[i], prev_rd[i], tx_busy[i]}, 0);
        end
        prev_rd[i] = fifo_rd[i];

        if (!in_f[i] && tx[i] == 1'b0 && prev_tx[i] == 1'b1) begin
          in_f[i]     = 1'b1;
          t_cnt[i]    = 0;
          stop_cnt[i] = 0;
          stable[i]   = 1'b1;
          samp[i]     = '0;
          if (i == 0 && exp_q0.size() > 0) begin
            cur[i] = exp_q0.pop_front();
          end else if (i == 1 && exp_q1.size() > 0) begin
            cur[i] = exp_q1.pop_front();
          end else begin
            chk("unexpected_frame", 1, 0);
            cur[i].data      = 8'h00;
            cur[i].stop_clks = 0;
            cur[i].b2b       = 1'b0;
          end
          if (cur[i].b2b) chk("idle_gap", cyc - last_done[i], 4);
        end

        if (!in_f[i] && tx_done_tick[i]) chk("stray_done", 1, 0);

        if (in_f[i]) begin
          if (t_cnt[i] < BODY_CLKS) begin
            if (t_cnt[i] % BIT_CLKS == 0) cur_bit[i] = tx[i];
            else if (tx[i] !== cur_bit[i]) stable[i] = 1'b0;
            if (t_cnt[i] % BIT_CLKS == BIT_CLKS / 2) samp[i][t_cnt[i] / BIT_CLKS] = tx[i];
          end else begin
            if (tx[i] !== 1'b1) stable[i] = 1'b0;
            stop_cnt[i]++;
          end
          if (tx_done_tick[i]) begin
            chk("start_bit", samp[i][0], 0);
            chk("data_byte", samp[i][8:1], cur[i].data);
            chk("bit_stable", stable[i], 1);
            chk("stop_len", stop_cnt[i], cur[i].stop_clks);
            chk("frame_len", t_cnt[i] + 1, BODY_CLKS + cur[i].stop_clks);
            $display("frame inst=%0d data=%02h expected=%02h len=%0d stop=%0d",
                     i, samp[i][8:1], cur[i].data, t_cnt[i] + 1, stop_cnt[i]);
            last_done[i] = cyc;
            done_cnt[i]++;
            in_f[i] = 1'b0;
          end else if (t_cnt[i] > 1200) begin
            chk("frame_overrun", 1, 0);
            in_f[i] = 1'b0;
          end
          t_cnt[i]++;
        end
        prev_tx[i] = tx[i];
      end
    end
  end

  task automatic wait_done(input int inst, input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt[inst] < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", done_cnt[inst] >= target, 1);
  endtask

  initial begin
    int bad_rd, bad_tx, bad_busy, rd0, d0, n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_fifo_rd", fifo_rd[i], 0);
      chk("rst_busy", tx_busy[i], 0);
      chk("rst_done", tx_done_tick[i], 0);
    end
    reset = 1'b0;

    // Empty FIFO: line idle, no pops
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    repeat (500) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (fifo_rd[i] !== 1'b0) bad_rd++;
        if (tx[i] !== 1'b1) bad_tx++;
        if (tx_busy[i] !== 1'b0) bad_busy++;
      end
    end
    chk("idle_no_rd", bad_rd, 0);
    chk("idle_tx_high", bad_tx, 0);
    chk("idle_not_busy", bad_busy, 0);

    // Single byte 0x55
    rd0 = rd_ptr[0];
    push_byte(0, 8'h55, 64, 1'b0);
    wait_done(0, 1, 2000);
    @(negedge clk);
    chk("pops_55", rd_ptr[0] - rd0, 1);

    // Back-to-back 0xA3, 0x0F
    rd0 = rd_ptr[0];
    push_byte(0, 8'hA3, 64, 1'b0);
    push_byte(0, 8'h0F, 64, 1'b1);
    wait_done(0, 3, 3000);
    repeat (10) @(negedge clk);
    chk("pops_a3_0f", rd_ptr[0] - rd0, 2);

    // Two stop bits, 0xFF
    push_byte(1, 8'hFF, 128, 1'b0);
    wait_done(1, 1, 2000);
    chk("pops_ff", rd_ptr[1], 1);

    // Reset during bit 3 of 0x81
    push_byte(0, 8'h81, 64, 1'b0);
    n = 0;
    while (!(in_f[0] && t_cnt[0] >= 280) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit3", n < 1000, 1);
    chk("bit3_low", tx[0], 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", tx[0], 1);
    chk("mid_rst_busy", tx_busy[0], 0);
    chk("mid_rst_rd", fifo_rd[0], 0);
    rd0 = rd_ptr[0];
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad_rd = 0; bad_tx = 0;
    repeat (200) begin
      @(negedge clk);
      if (fifo_rd[0] !== 1'b0) bad_rd++;
      if (tx[0] !== 1'b1) bad_tx++;
    end
    chk("post_rst_no_rd", bad_rd, 0);
    chk("post_rst_tx_high", bad_tx, 0);
    chk("post_rst_pops", rd_ptr[0] - rd0, 0);

    // FIFO goes non-empty in the last STOP cycle
    d0 = done_cnt[0];
    push_byte(0, 8'h3C, 64, 1'b0);
    n = 0;
    while (tx_done_tick[0] !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_stop_end", tx_done_tick[0], 1);
    push_byte(0, 8'h96, 64, 1'b1);
    #1;
    chk("no_rd_in_stop", fifo_rd[0], 0);
    @(posedge clk);
    #1;
    chk("rd_in_idle", fifo_rd[0], 1);
    chk("idle_after_stop", tx_busy[0], 0);
    wait_done(0, d0 + 2, 2000);

    repeat (5) @(negedge clk);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
